// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES core scheduler: FSM state encoding,
// block width and requester-id sizing.
package aes_sched_pkg;

    localparam int AES_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Width of a requester id; a single requester still gets one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/aes_tag_fifo.sv
// In-order tag FIFO recording which requester owns each block in the core.
// Supports push and pop in the same cycle; pointers wrap modulo DEPTH.
module aes_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Round-robin scheduler sharing one AES-128 core among NUM_REQ requesters;
// results are matched to owners strictly in issue order via the tag FIFO.
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int ID_W  = id_w(NUM_REQ),
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*AES_W-1:0] req_plain,
    input  logic [NUM_REQ*AES_W-1:0] req_key,
    output logic                     core_valid_in,
    output logic [AES_W-1:0]         core_plain_text,
    output logic [AES_W-1:0]         core_cipher_key,
    input  logic                     core_valid_out,
    input  logic [AES_W-1:0]         core_cipher_text,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [AES_W-1:0]         rsp_cipher,
    output logic                     idle,
    output logic                     orphan_err
);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic             grant;
    logic             can_grant;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  fifo_head;
    logic [CNT_W-1:0] inflight;

    aes_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data (grant_idx),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (inflight)
    );

    // Credit check uses the registered occupancy, so a pop never frees a slot
    // for a grant in the same cycle.
    assign can_grant = !reset && (state_q == RUN) && enable && !fifo_full;
    assign pop       = core_valid_out && !fifo_empty;
    assign idle      = (state_q == IDLE) && (inflight == '0);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_add(int'(rr_ptr), k, NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(wrap_add(int'(rr_ptr), k, NUM_REQ));
            end
        end
        grant = grant_found && can_grant;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = (inflight != '0) ? DRAIN : IDLE;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (inflight == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr          <= '0;
            core_valid_in   <= 1'b0;
            core_plain_text <= '0;
            core_cipher_key <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_cipher      <= '0;
            orphan_err      <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_valid_in <= grant;
            rsp_valid     <= pop;
            if (grant) begin
                core_plain_text <= req_plain[int'(grant_idx)*AES_W +: AES_W];
                core_cipher_key <= req_key[int'(grant_idx)*AES_W +: AES_W];
                rr_ptr          <= ID_W'(wrap_add(int'(grant_idx), 1, NUM_REQ));
            end
            if (pop) begin
                rsp_id     <= fifo_head;
                rsp_cipher <= core_cipher_text;
            end
            // A result with no owner is dropped but remembered until reset.
            if (core_valid_out && fifo_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed self-checking bench: two scheduler instances (depth 4 with a
// 2-cycle core model, depth 2 with a 5-cycle core model).
module tb_aes_core_scheduler;
    import aes_sched_pkg::*;

    localparam int N = 4;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset = 1'b1;
    logic               inject = 1'b0;
    logic [N*128-1:0]   req_plain = '0;
    logic [N*128-1:0]   req_key = '0;

    logic               a_enable = 1'b0;
    logic [N-1:0]       a_req_valid = '0;
    logic [N-1:0]       a_req_ready;
    logic               a_cvi, a_cvo, a_rsp_valid, a_idle, a_orphan;
    logic [127:0]       a_cpt, a_cck, a_cct, a_rsp_cipher;
    logic [1:0]         a_rsp_id;

    logic               b_enable = 1'b0;
    logic [N-1:0]       b_req_valid = '0;
    logic [N-1:0]       b_req_ready;
    logic               b_cvi, b_cvo, b_rsp_valid, b_idle, b_orphan;
    logic [127:0]       b_cpt, b_cck, b_cct, b_rsp_cipher;
    logic [1:0]         b_rsp_id;

    int vectors = 0;
    int miscompares = 0;

    aes_core_scheduler #(.NUM_REQ(N), .MAX_INFLIGHT(4)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_plain(req_plain), .req_key(req_key),
        .core_valid_in(a_cvi), .core_plain_text(a_cpt), .core_cipher_key(a_cck),
        .core_valid_out(a_cvo), .core_cipher_text(a_cct),
        .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_cipher(a_rsp_cipher),
        .idle(a_idle), .orphan_err(a_orphan)
    );

    aes_core_scheduler #(.NUM_REQ(N), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_plain(req_plain), .req_key(req_key),
        .core_valid_in(b_cvi), .core_plain_text(b_cpt), .core_cipher_key(b_cck),
        .core_valid_out(b_cvo), .core_cipher_text(b_cct),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_cipher(b_rsp_cipher),
        .idle(b_idle), .orphan_err(b_orphan)
    );

    // Stand-in core: the FIPS-197 result for its known vector, plain^key otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
        if (p == FIPS_P && k == FIPS_K) return FIPS_C;
        return p ^ k;
    endfunction

    function automatic logic [127:0] plain_of(input int i);
        return {4{32'hA5A5_0000 | 32'(i)}};
    endfunction

    function automatic logic [127:0] key_of(input int i);
        return {4{32'h0F0F_1000 + 32'(i) * 32'h11}};
    endfunction

    logic [1:0]   a_pv;
    logic [127:0] a_pd [2];
    logic [4:0]   b_pv;
    logic [127:0] b_pd [5];

    always @(posedge clk) begin
        if (reset) a_pv <= '0;
        else       a_pv <= {a_pv[0], a_cvi};
        a_pd[0] <= core_fn(a_cpt, a_cck);
        a_pd[1] <= a_pd[0];
    end

    always @(posedge clk) begin
        if (reset) b_pv <= '0;
        else       b_pv <= {b_pv[3:0], b_cvi};
        b_pd[0] <= core_fn(b_cpt, b_cck);
        for (int i = 1; i < 5; i++) b_pd[i] <= b_pd[i-1];
    end

    assign a_cvo = a_pv[1] | inject;
    assign a_cct = a_pd[1];
    assign b_cvo = b_pv[4];
    assign b_cct = b_pd[4];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_default_data();
        for (int i = 0; i < N; i++) begin
            req_plain[128*i +: 128] = plain_of(i);
            req_key[128*i +: 128]   = key_of(i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_enable = 1'b0; a_req_valid = '0;
        b_enable = 1'b0; b_req_valid = '0;
        inject = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready_a(output bit found);
        found = 1'b0;
        #1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (a_req_ready != '0) found = 1'b1;
            else begin tick(); #1; end
        end
    endtask

    task automatic wait_ready_b(output bit found);
        found = 1'b0;
        #1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (b_req_ready != '0) found = 1'b1;
            else begin tick(); #1; end
        end
    endtask

    task automatic test_reset();
        a_enable = 1'b1; a_req_valid = '1;
        b_enable = 1'b1; b_req_valid = '1;
        #1;
        vectors++;
        if (a_req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready_a: got %b, expected 0000", a_req_ready); end
        vectors++;
        if (b_req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready_b: got %b, expected 0000", b_req_ready); end
        tick();
        vectors++;
        if ({a_cvi, a_rsp_valid, a_orphan} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_strobes: got %b, expected 000", {a_cvi, a_rsp_valid, a_orphan}); end
        vectors++;
        if (a_cpt !== '0 || a_cck !== '0) begin miscompares++; $display("[TB] FAIL reset_core_data: got %h/%h, expected 0/0", a_cpt, a_cck); end
        vectors++;
        if (a_rsp_id !== 2'd0 || a_rsp_cipher !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp: got %0d/%h, expected 0/0", a_rsp_id, a_rsp_cipher); end
        vectors++;
        if (a_idle !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_idle: got %b, expected 1", a_idle); end
        do_reset();
    endtask

    task automatic test_single();
        bit found;
        do_reset();
        req_plain[256 +: 128] = FIPS_P;
        req_key[256 +: 128]   = FIPS_K;
        a_enable = 1'b1; a_req_valid = 4'b0100;
        wait_ready_a(found);
        vectors++;
        if (!found || a_req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_grant: got %b, expected 0100", a_req_ready); return; end
        tick(); a_req_valid = '0;
        vectors++;
        if (a_cvi !== 1'b1 || a_cpt !== FIPS_P || a_cck !== FIPS_K) begin miscompares++; $display("[TB] FAIL single_issue: got %b %h %h, expected 1 %h %h", a_cvi, a_cpt, a_cck, FIPS_P, FIPS_K); end
        tick();
        vectors++;
        if (a_cvi !== 1'b0 || a_cpt !== FIPS_P) begin miscompares++; $display("[TB] FAIL single_hold: got %b %h, expected 0 %h", a_cvi, a_cpt, FIPS_P); end
        tick();
        vectors++;
        if (a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_rsp: got %b, expected 0", a_rsp_valid); end
        tick();
        vectors++;
        if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd2 || a_rsp_cipher !== FIPS_C) begin miscompares++; $display("[TB] FAIL single_rsp: got %b id %0d %h, expected 1 id 2 %h", a_rsp_valid, a_rsp_id, a_rsp_cipher, FIPS_C); end
        tick();
        vectors++;
        if (a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rsp_pulse: got %b, expected 0", a_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        bit found;
        logic [N-1:0] exp_ready;
        int id;
        do_reset();
        load_default_data();
        a_enable = 1'b1; a_req_valid = '1;
        wait_ready_a(found);
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL b2b_timeout: got no grant, expected grant within 10 cycles"); return; end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin tick(); #1; end
            exp_ready = 4'b0001 << (k % 4);
            vectors++;
            if (a_req_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL b2b_grant%0d: got %b, expected %b", k, a_req_ready, exp_ready); end
            if (k >= 4) begin
                id = (k - 4) % 4;
                vectors++;
                if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'(id) || a_rsp_cipher !== (plain_of(id) ^ key_of(id))) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_rsp%0d: got %b id %0d %h, expected 1 id %0d %h", k, a_rsp_valid, a_rsp_id, a_rsp_cipher, id, plain_of(id) ^ key_of(id));
                end
            end
        end
        a_req_valid = '0;
    endtask

    task automatic test_max_inflight();
        bit found;
        logic [N-1:0] exp_ready;
        logic exp_rsp;
        int gi, ri;
        do_reset();
        load_default_data();
        b_enable = 1'b1; b_req_valid = '1;
        wait_ready_b(found);
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL credit_timeout: got no grant, expected grant within 10 cycles"); return; end
        for (int off = 0; off < 24; off++) begin
            if (off > 0) begin tick(); #1; end
            gi = (off / 7) * 2 + (off % 7);
            exp_ready = ((off % 7) < 2) ? (4'b0001 << (gi % 4)) : 4'b0000;
            vectors++;
            if (b_req_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL credit_ready%0d: got %b, expected %b", off, b_req_ready, exp_ready); end
            exp_rsp = (off >= 7) && (((off - 7) % 7) < 2);
            ri = ((off - 7) / 7) * 2 + ((off - 7) % 7);
            vectors++;
            if (b_rsp_valid !== exp_rsp) begin miscompares++; $display("[TB] FAIL credit_rspv%0d: got %b, expected %b", off, b_rsp_valid, exp_rsp); end
            else if (exp_rsp && (b_rsp_id !== 2'(ri % 4) || b_rsp_cipher !== (plain_of(ri % 4) ^ key_of(ri % 4)))) begin
                miscompares++;
                $display("[TB] FAIL credit_rsp%0d: got id %0d %h, expected id %0d %h", off, b_rsp_id, b_rsp_cipher, ri % 4, plain_of(ri % 4) ^ key_of(ri % 4));
            end
        end
        b_req_valid = '0; b_enable = 1'b0;
    endtask

    task automatic test_drain();
        bit found;
        logic exp_rsp;
        do_reset();
        load_default_data();
        a_enable = 1'b1; a_req_valid = '1;
        wait_ready_a(found);
        vectors++;
        if (!found || a_req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL drain_grant: got %b, expected 0001", a_req_ready); return; end
        tick(); tick(); tick();
        a_enable = 1'b0;
        #1;
        vectors++;
        if (a_req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL drain_stop: got %b, expected 0000", a_req_ready); end
        for (int j = 1; j <= 6; j++) begin
            tick(); #1;
            exp_rsp = (j <= 3);
            vectors++;
            if (a_rsp_valid !== exp_rsp || a_req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL drain_rspv%0d: got %b ready %b, expected %b ready 0000", j, a_rsp_valid, a_req_ready, exp_rsp); end
            if (exp_rsp) begin
                vectors++;
                if (a_rsp_id !== 2'(j - 1)) begin miscompares++; $display("[TB] FAIL drain_id%0d: got %0d, expected %0d", j, a_rsp_id, j - 1); end
            end
            if (j == 3 || j == 4) begin
                vectors++;
                if (a_idle !== (j == 4)) begin miscompares++; $display("[TB] FAIL drain_idle%0d: got %b, expected %b", j, a_idle, j == 4); end
            end
        end
        a_req_valid = '0;
    endtask

    task automatic test_orphan();
        do_reset();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        vectors++;
        if (a_orphan !== 1'b1 || a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL orphan_set: got err %b rsp %b, expected err 1 rsp 0", a_orphan, a_rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (a_orphan !== 1'b1 || a_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL orphan_sticky%0d: got err %b rsp %b, expected err 1 rsp 0", i, a_orphan, a_rsp_valid); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (a_orphan !== 1'b0) begin miscompares++; $display("[TB] FAIL orphan_clear: got %b, expected 0", a_orphan); end
    endtask

    task automatic test_reset_midflight();
        bit found;
        do_reset();
        load_default_data();
        a_enable = 1'b1; a_req_valid = '1;
        wait_ready_a(found);
        vectors++;
        if (!found) begin miscompares++; $display("[TB] FAIL midrst_timeout: got no grant, expected grant within 10 cycles"); return; end
        tick(); tick(); tick();
        reset = 1'b1; a_enable = 1'b0; a_req_valid = '0;
        tick();
        vectors++;
        if ({a_cvi, a_rsp_valid, a_orphan, a_idle} !== 4'b0001) begin miscompares++; $display("[TB] FAIL midrst_flags: got %b, expected 0001", {a_cvi, a_rsp_valid, a_orphan, a_idle}); end
        vectors++;
        if (a_cpt !== '0 || a_cck !== '0 || a_rsp_id !== 2'd0 || a_rsp_cipher !== '0) begin miscompares++; $display("[TB] FAIL midrst_data: got %h %h %0d %h, expected zeros", a_cpt, a_cck, a_rsp_id, a_rsp_cipher); end
        reset = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (a_rsp_valid !== 1'b0 || a_orphan !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_stale: got rsp %b err %b, expected 0 0", a_rsp_valid, a_orphan); end
        a_enable = 1'b1; a_req_valid = 4'b1000;
        wait_ready_a(found);
        vectors++;
        if (!found || a_req_ready !== 4'b1000) begin miscompares++; $display("[TB] FAIL midrst_grant: got %b, expected 1000", a_req_ready); return; end
        tick(); a_req_valid = '0;
        tick(); tick(); tick();
        vectors++;
        if (a_rsp_valid !== 1'b1 || a_rsp_id !== 2'd3 || a_rsp_cipher !== (plain_of(3) ^ key_of(3))) begin
            miscompares++;
            $display("[TB] FAIL midrst_rsp: got %b id %0d %h, expected 1 id 3 %h", a_rsp_valid, a_rsp_id, a_rsp_cipher, plain_of(3) ^ key_of(3));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_max_inflight();
        test_drain();
        test_orphan();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_core_scheduler.md
# aes_core_scheduler

Round-robin scheduler that shares one AES-128 encryption core (the registered core wrapper, 2-cycle valid_in→valid_out latency, one new block accepted per cycle) among NUM_REQ requesters. It arbitrates requests and forwards the selected plaintext/key to the core. It tracks which requester owns each in-flight block in an in-order tag FIFO, then returns each ciphertext tagged with its requester ID. It sits between the requester ports and the core wrapper. It is latency-agnostic: responses are matched strictly in issue order.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_INFLIGHT, 4: maximum blocks outstanding in the core; tag FIFO depth; power of 2, ≥2.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; high = grant requests, low = stop granting and drain.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; combinational, one-hot or zero.
- req_plain  in  NUM_REQ*128  plaintexts; requester i occupies bits [128i+127:128i].
- req_key  in  NUM_REQ*128  keys; same packing as req_plain.
- core_valid_in  out  1  issue strobe to the core; registered.
- core_plain_text  out  128  plaintext to the core; registered.
- core_cipher_key  out  128  key to the core; registered.
- core_valid_out  in  1  core result valid.
- core_cipher_text  in  128  core result.
- rsp_valid  out  1  response strobe; one cycle, no backpressure.
- rsp_id  out  $clog2(NUM_REQ)  owner of the response.
- rsp_cipher  out  128  ciphertext.
- idle  out  1  high when state is IDLE and inflight == 0.
- orphan_err  out  1  sticky; a core result arrived while the tag FIFO was empty.

## Operation
- FSM states are IDLE, RUN and DRAIN. Reset enters IDLE.
  - IDLE→RUN when enable = 1.
  - RUN→DRAIN when enable = 0 and inflight > 0.
  - RUN→IDLE when enable = 0 and inflight = 0.
  - DRAIN→IDLE when inflight reaches 0.
  - DRAIN→RUN when enable returns to 1.
- Grants occur only in RUN with inflight < MAX_INFLIGHT. The grantee is the first requester with req_valid = 1, searched from rr_ptr upward with wrap-around. The handshake is req_valid & req_ready.
- After a grant to requester g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- On a grant:
  - Register the selected plain and key onto the core_* outputs.
  - Pulse core_valid_in the next cycle.
  - Push g into the tag FIFO.
  - Increment inflight.
- When core_valid_out = 1 and the FIFO is non-empty: pop the head, register rsp_id = head and rsp_cipher = core_cipher_text, pulse rsp_valid, and decrement inflight.
- Push and pop in the same cycle leave inflight unchanged. The FIFO pointers wrap modulo MAX_INFLIGHT.
- When core_valid_out = 1 and the FIFO is empty: set orphan_err, drop the data, do not assert rsp_valid. orphan_err is cleared only by reset.
- inflight is $clog2(MAX_INFLIGHT)+1 bits wide and never exceeds MAX_INFLIGHT.
- core_plain_text and core_cipher_key hold their last issued value while core_valid_in = 0.

## Timing
- Reset values: core_valid_in = 0, core_plain_text = 0, core_cipher_key = 0, rsp_valid = 0, rsp_id = 0, rsp_cipher = 0, orphan_err = 0, rr_ptr = 0, inflight = 0, FIFO empty, state IDLE, idle = 1. req_ready = 0 during the reset cycle.
- Handshake at cycle T gives core_valid_in at T+1. The core returns at T+3, and rsp_valid is asserted at T+4. Request-to-response latency is 4 cycles.
- Sustained throughput is one block per cycle. MAX_INFLIGHT ≥ 4 is needed for full rate with the 2-cycle core.
- At inflight = MAX_INFLIGHT, req_ready is 0. A pop in that cycle does not enable a same-cycle grant; the credit check uses the registered count.
- enable falling at cycle T: no grant at T. Responses already in flight still complete.
- Reset mid-operation: everything is flushed. The core shares the reset, so no stale results are expected. Any stale result that does arrive sets orphan_err.

## Structure
- Package aes_sched_pkg holds the state enum (IDLE, RUN, DRAIN), the AES_W = 128 constant, and the id-width helper.
- Sub-module aes_tag_fifo: synchronous FIFO with parameterised width and depth, push/pop/full/empty/count, and same-cycle push+pop supported.

## Test plan
- Single request: requester 2, key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff → rsp_valid at T+4 with rsp_id = 2 and rsp_cipher = 69c4e0d86a7b0430d8cdb78070b4c55a.
- All 4 requesters valid continuously from reset → grants in order 0,1,2,3,0,…, one per cycle. rsp_id sequence matches grant order.
- MAX_INFLIGHT = 2, core model latency stretched to 5 cycles → req_ready drops when 2 blocks are outstanding. No response is lost, and inflight never exceeds 2.
- Issue 3 blocks, then deassert enable → no further grants. Exactly 3 responses arrive, state goes DRAIN→IDLE, and idle = 1 after the last response.
- Inject core_valid_out with no prior issue → orphan_err = 1 and stays 1, rsp_valid stays 0. Reset clears orphan_err.
- Assert reset with 3 blocks in flight → all outputs return to reset values the next cycle. A new request after reset completes normally with correct rsp_id.
